// File: rtl/handshake_const_arbiter.sv
// handshake_const_arbiter: round-robin arbiter sharing one registered constant output among NUM_REQ requesters.
// Define HANDSHAKE_CONST_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module handshake_const_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ = 4,
  parameter int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter logic [NUM_REQ*DATA_WIDTH-1:0] CONST_TABLE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    ctrl_valid,
  output logic [NUM_REQ-1:0]    ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [IDX_W-1:0]      outs_idx,
  output logic                  outs_valid,
  input  logic                  outs_ready
);
  logic             full;
  logic             grant;
  logic [IDX_W-1:0] win;
  logic             can_load;
  logic             fire;

  assign can_load   = !full || outs_ready;
  assign fire       = grant && can_load;
  assign outs_valid = full;
  assign ctrl_ready = (fire && !rst) ? NUM_REQ'(1) << win : '0;

`ifdef HANDSHAKE_CONST_ARB_FIXED_PRIO_EN
  // Lowest asserted index wins; scanning downwards lets the last hit be the lowest.
  always_comb begin
    grant = 1'b0;
    win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (ctrl_valid[k]) begin
        grant = 1'b1;
        win   = IDX_W'(k);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;

  // Scan from rr_ptr upwards modulo NUM_REQ; reverse order makes the first hit in scan order stick.
  always_comb begin
    grant = 1'b0;
    win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (ctrl_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant = 1'b1;
        win   = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Pointer moves just past the winner on each accepted token and wraps at NUM_REQ-1.
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else if (fire) rr_ptr <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  end
`endif

  // Output register: load the winner's constant on fire, otherwise drain when downstream accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= 1'b0;
      outs     <= '0;
      outs_idx <= '0;
    end else if (fire) begin
      full     <= 1'b1;
      outs     <= CONST_TABLE[int'(win)*DATA_WIDTH +: DATA_WIDTH];
      outs_idx <= win;
    end else if (outs_ready) begin
      full     <= 1'b0;
    end
  end
endmodule

// File: tb/tb_handshake_const_arbiter.sv
// tb_handshake_const_arbiter: directed self-checking bench for handshake_const_arbiter.
module tb_handshake_const_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ctrl_valid;
  logic [3:0]  ctrl_ready;
  logic [31:0] outs;
  logic [1:0]  outs_idx;
  logic        outs_valid;
  logic        outs_ready;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] tbl [4] = '{32'h5F78E7F2, 32'h00000001, 32'hDEADBEEF, 32'h3F800000};

  handshake_const_arbiter #(
    .DATA_WIDTH(32),
    .NUM_REQ(4),
    .CONST_TABLE({32'h3F800000, 32'hDEADBEEF, 32'h00000001, 32'h5F78E7F2})
  ) dut (
    .clk(clk),
    .rst(rst),
    .ctrl_valid(ctrl_valid),
    .ctrl_ready(ctrl_ready),
    .outs(outs),
    .outs_idx(outs_idx),
    .outs_valid(outs_valid),
    .outs_ready(outs_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic r);
    ctrl_valid = v;
    outs_ready = r;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic out_chk(input string tag, input logic v, input logic [1:0] i, input logic [31:0] d);
    chk({tag, "_valid"}, 32'(outs_valid), 32'(v));
    chk({tag, "_idx"}, 32'(outs_idx), 32'(i));
    chk({tag, "_data"}, outs, d);
  endtask

  initial begin
    rst = 1'b1;
    drive(4'hF, 1'b1);
    chk("rst_ready_comb", 32'(ctrl_ready), 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("rst_ready", 32'(ctrl_ready), 32'h0);
      out_chk("rst_out", 1'b0, 2'd0, 32'h0);
    end
    rst = 1'b0;
`ifdef HANDSHAKE_CONST_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) begin
      drive(4'hF, 1'b1);
      chk("fp_ready", 32'(ctrl_ready), 32'h1);
      tick;
      out_chk("fp_out", 1'b1, 2'd0, tbl[0]);
    end
    drive(4'hE, 1'b1);
    chk("fp_drop0_ready", 32'(ctrl_ready), 32'h2);
    tick;
    out_chk("fp_drop0_out", 1'b1, 2'd1, tbl[1]);
`else
    for (int i = 0; i < 8; i++) begin
      drive(4'hF, 1'b1);
      chk("rr_ready", 32'(ctrl_ready), 32'(4'b0001 << (i % 4)));
      tick;
      out_chk("rr_out", 1'b1, 2'(i % 4), tbl[i % 4]);
    end
    drive(4'hF, 1'b0);
    chk("bp_ready_init", 32'(ctrl_ready), 32'h0);
    for (int c = 0; c < 5; c++) begin
      tick;
      chk("bp_ready", 32'(ctrl_ready), 32'h0);
      out_chk("bp_hold", 1'b1, 2'd3, tbl[3]);
    end
    drive(4'hF, 1'b1);
    chk("bp_release_ready", 32'(ctrl_ready), 32'h1);
    tick;
    out_chk("bp_release_out", 1'b1, 2'd0, tbl[0]);
    drive(4'b0010, 1'b1);
    chk("sp_ready1", 32'(ctrl_ready), 32'h2);
    tick;
    out_chk("sp_out1", 1'b1, 2'd1, tbl[1]);
    drive(4'b1000, 1'b1);
    chk("sp_ready3", 32'(ctrl_ready), 32'h8);
    tick;
    out_chk("sp_out3", 1'b1, 2'd3, tbl[3]);
    drive(4'b1001, 1'b1);
    chk("sp_wrap_ready", 32'(ctrl_ready), 32'h1);
    tick;
    out_chk("sp_wrap_out", 1'b1, 2'd0, tbl[0]);
    drive(4'b0000, 1'b1);
    chk("drain_ready", 32'(ctrl_ready), 32'h0);
    tick;
    out_chk("drain_out", 1'b0, 2'd0, tbl[0]);
    drive(4'b1001, 1'b1);
    chk("hold_ptr_ready", 32'(ctrl_ready), 32'h8);
    tick;
    out_chk("hold_ptr_out", 1'b1, 2'd3, tbl[3]);
    drive(4'hF, 1'b0);
    chk("mid_stall_ready", 32'(ctrl_ready), 32'h0);
    tick;
    out_chk("mid_stall_out", 1'b1, 2'd3, tbl[3]);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(ctrl_ready), 32'h0);
    tick;
    out_chk("mid_rst_out", 1'b0, 2'd0, 32'h0);
    rst = 1'b0;
    drive(4'hF, 1'b1);
    chk("restart_ready", 32'(ctrl_ready), 32'h1);
    tick;
    out_chk("restart_out", 1'b1, 2'd0, tbl[0]);
    drive(4'b0100, 1'b1);
    chk("restart2_ready", 32'(ctrl_ready), 32'h4);
    tick;
    out_chk("restart2_out", 1'b1, 2'd2, tbl[2]);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
